// File: rtl/dmem_pkg.sv
// Address map and STATUS layout shared by the data-memory responder and its testbench.
package dmem_pkg;

    localparam logic [7:0] RAM_TOP  = 8'hEF;
    localparam logic [7:0] OUT_DATA = 8'hF0;
    localparam logic [7:0] STATUS   = 8'hF1;
    localparam logic [7:0] CNT_LO   = 8'hF2;
    localparam logic [7:0] CNT_HI   = 8'hF3;

    localparam int RAM_WORDS = 240;

    localparam int STATUS_OVF_BIT   = 7;
    localparam int STATUS_FULL_BIT  = 6;
    localparam int STATUS_EMPTY_BIT = 5;
    localparam int STATUS_CNT_W     = 3;

    function automatic logic [7:0] pack_status(input logic ovf, input logic full,
                                               input logic empty,
                                               input logic [STATUS_CNT_W-1:0] cnt);
        logic [7:0] s;
        s = '0;
        s[STATUS_OVF_BIT]          = ovf;
        s[STATUS_FULL_BIT]         = full;
        s[STATUS_EMPTY_BIT]        = empty;
        s[STATUS_CNT_W-1:0]        = cnt;
        return s;
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Output FIFO: push dropped when full unless a pop frees a slot at the same edge.
module out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             dropped
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign dropped  = push && full && !do_pop;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Processor data-port responder: 240-byte RAM, output FIFO, status byte and
// a free-running cycle counter with a high-byte shadow latched on low-byte reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_addr,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [7:0] data_write,
    output logic [7:0] data_read,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]  ram [RAM_WORDS];
    logic [15:0] cycle_cnt;
    logic [7:0]  cnt_shadow;
    logic        ovf;
    logic        ram_sel;
    logic        fifo_push;
    logic        fifo_pop;
    logic        status_wr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_dropped;
    logic [CW-1:0] fifo_count;
    logic [7:0]  status_byte;

    assign ram_sel   = (data_addr <= RAM_TOP);
    assign fifo_push = mem_write && (data_addr == OUT_DATA);
    assign status_wr = mem_write && (data_addr == STATUS);
    assign fifo_pop  = out_valid && out_ready;
    assign out_valid = !fifo_empty;

    out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (data_write),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped)
    );

    assign status_byte = pack_status(ovf, fifo_full, fifo_empty, STATUS_CNT_W'(fifo_count));

    // RAM is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_write && ram_sel) begin
            ram[data_addr] <= data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt  <= '0;
            cnt_shadow <= '0;
            ovf        <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (mem_read && (data_addr == CNT_LO)) begin
                cnt_shadow <= cycle_cnt[15:8];
            end
            // Clear has priority over a same-cycle overflow.
            if (status_wr) begin
                ovf <= 1'b0;
            end else if (fifo_dropped) begin
                ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        data_read = '0;
        if (mem_read) begin
            if (ram_sel) begin
                data_read = ram[data_addr];
            end else begin
                case (data_addr)
                    STATUS:  data_read = status_byte;
                    CNT_LO:  data_read = cycle_cnt[7:0];
                    CNT_HI:  data_read = cnt_shadow;
                    default: data_read = '0;
                endcase
            end
        end
    end

endmodule
